// File: rtl/ov7670_pkg.sv
// Shared OV7670 definitions: pixel format codes, capture FSM states and
// the byte-pair to 12-bit pixel conversions used by capture and display blocks.
package ov7670_pkg;

    localparam logic [1:0] MODE_RGB444 = 2'b00;
    localparam logic [1:0] MODE_GREY   = 2'b01;

    typedef enum logic [1:0] {
        ST_UNSYNCED   = 2'b00,
        ST_WAIT_FRAME = 2'b01,
        ST_ACTIVE     = 2'b10
    } cap_state_e;

    // RGB565 {R5,G6,B5} split over hi/lo bytes -> {R[4:1], G[5:2], B[4:1]}
    function automatic logic [11:0] rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

    // Luma byte -> grey pixel with the top nibble replicated on all channels
    function automatic logic [11:0] y_to_grey444(input logic [7:0] y);
        return {y[7:4], y[7:4], y[7:4]};
    endfunction

endpackage

// File: rtl/ov7670_pix_pack.sv
// Byte pairing for the OV7670 DVP bus: tracks the byte phase within a line,
// holds the high byte and presents the converted pixel together with a
// pix_valid strobe during the cycle its low byte is on d.
module ov7670_pix_pack
    import ov7670_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  d,
    input  logic [1:0]  mode,
    output logic        pix_valid,
    output logic [11:0] pix
);

    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;
    logic       byte_act;

    // Blanking wins over href; outside an active byte the phase restarts at the high byte
    assign byte_act = href & ~vsync;

    // Next phase and high-byte hold
    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        if (!byte_act) begin
            phase_d = 1'b0;
        end else begin
            if (!phase_q) hi_d = d;
            phase_d = ~phase_q;
        end
    end

    // Phase and high-byte registers
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
            hi_q    <= 8'd0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

    // Pixel completes on the low byte; unknown mode codes fall back to RGB
    always_comb begin
        pix_valid = byte_act & phase_q;
        if (mode == MODE_GREY) pix = y_to_grey444(hi_q);
        else                   pix = rgb565_to_444(hi_q, d);
    end

endmodule

// File: rtl/ov7670_capture_win.sv
// OV7670 windowed capture: frame sync FSM, x/y position tracking, crop and
// 2:1 decimation, linear frame-buffer write addressing, line-length check
// and completed-frame counting. Everything runs on pclk.
module ov7670_capture_win
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int CROP_X0  = 0,
    parameter int CROP_Y0  = 0,
    parameter int CROP_W   = 320,
    parameter int CROP_H   = 240,
    parameter int DECIM    = 2,
    parameter int ADDR_W   = 17
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic              line_err,
    output logic [7:0]        frame_cnt
);

    localparam int X_END  = CROP_X0 + CROP_W * DECIM;
    localparam int Y_END  = CROP_Y0 + CROP_H * DECIM;
    localparam int N_PIX  = CROP_W * CROP_H;
    localparam int LINE_B = 2 * H_ACTIVE;
    localparam int X_W    = $clog2(H_ACTIVE + 1);
    localparam int Y_W    = $clog2(Y_END + 1);
    localparam int B_W    = $clog2(LINE_B + 2);
    localparam bit DEC_ON = (DECIM == 2);

    cap_state_e        state_q, state_d;
    logic              capturing_q, capturing_d;
    logic [1:0]        mode_q, mode_d;
    logic              href_prev_q, href_prev_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [B_W-1:0]    bcnt_q, bcnt_d;
    logic              xph_q, xph_d;
    logic              yph_q, yph_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              full_q, full_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       dout_q, dout_d;
    logic              we_q, we_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic              pix_valid;
    logic [11:0]       pix;
    logic              act, href_rise, href_fall;
    logic              x_in, y_in, keep;

    ov7670_pix_pack u_pack (
        .pclk      (pclk),
        .rst       (rst),
        .vsync     (vsync),
        .href      (href),
        .d         (d),
        .mode      (mode_q),
        .pix_valid (pix_valid),
        .pix       (pix)
    );

    // Line edges and crop/decimation decision for the pixel completing this cycle
    always_comb begin
        act       = href & ~vsync;
        href_rise = act & ~href_prev_q;
        href_fall = href_prev_q & ~href & ~vsync;
        x_in      = (int'(x_q) >= CROP_X0) && (int'(x_q) < X_END);
        y_in      = (int'(y_q) >= CROP_Y0) && (int'(y_q) < Y_END);
        keep      = (state_q == ST_ACTIVE) && capturing_q && !full_q && pix_valid &&
                    x_in && y_in && (!DEC_ON || (!xph_q && !yph_q));
    end

    // Next-state logic: sync FSM, position counters, write address, status pulses
    always_comb begin
        state_d      = state_q;
        capturing_d  = capturing_q;
        mode_d       = mode_q;
        href_prev_d  = act;
        x_d          = x_q;
        y_d          = y_q;
        bcnt_d       = bcnt_q;
        xph_d        = xph_q;
        yph_d        = yph_q;
        wptr_d       = wptr_q;
        full_d       = full_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        we_d         = 1'b0;
        frame_done_d = 1'b0;
        line_err_d   = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            ST_UNSYNCED: begin
                if (vsync) state_d = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (!vsync) begin
                    state_d     = ST_ACTIVE;
                    capturing_d = enable;
                    mode_d      = mode;
                    addr_d      = '0;
                    wptr_d      = '0;
                    full_d      = 1'b0;
                    y_d         = '0;
                    yph_d       = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (vsync) begin
                    state_d     = ST_WAIT_FRAME;
                    capturing_d = 1'b0;
                    if (capturing_q) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_UNSYNCED;
        endcase

        if (vsync) begin
            x_d    = '0;
            bcnt_d = '0;
            xph_d  = 1'b0;
        end else begin
            if (href_rise) begin
                x_d    = '0;
                bcnt_d = B_W'(1);
                xph_d  = 1'b0;
            end else if (act && int'(bcnt_q) < LINE_B + 1) begin
                bcnt_d = bcnt_q + B_W'(1);
            end

            if (pix_valid) begin
                if (int'(x_q) < H_ACTIVE) x_d = x_q + X_W'(1);
                if (x_in) xph_d = ~xph_q;
            end

            if (keep) begin
                we_d   = 1'b1;
                dout_d = pix;
                addr_d = wptr_q;
                if (int'(wptr_q) == N_PIX - 1) full_d = 1'b1;
                else                           wptr_d = wptr_q + ADDR_W'(1);
            end

            if (href_fall && state_q == ST_ACTIVE) begin
                if (int'(y_q) < Y_END) y_d = y_q + Y_W'(1);
                if (y_in) yph_d = ~yph_q;
                if (int'(bcnt_q) != LINE_B) line_err_d = 1'b1;
            end
        end
    end

    // State and output registers, all cleared asynchronously
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_UNSYNCED;
            capturing_q  <= 1'b0;
            mode_q       <= MODE_RGB444;
            href_prev_q  <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            bcnt_q       <= '0;
            xph_q        <= 1'b0;
            yph_q        <= 1'b0;
            wptr_q       <= '0;
            full_q       <= 1'b0;
            addr_q       <= '0;
            dout_q       <= '0;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            capturing_q  <= capturing_d;
            mode_q       <= mode_d;
            href_prev_q  <= href_prev_d;
            x_q          <= x_d;
            y_q          <= y_d;
            bcnt_q       <= bcnt_d;
            xph_q        <= xph_d;
            yph_q        <= yph_d;
            wptr_q       <= wptr_d;
            full_q       <= full_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            we_q         <= we_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign we         = we_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_capture_win.sv
// Directed bench for ov7670_capture_win with a 8-pixel line, 2x2 crop at
// (2,1) and 2:1 decimation; five sensor lines per frame.
module tb_ov7670_capture_win;

    localparam int H_ACTIVE = 8;
    localparam int ADDR_W   = 3;
    localparam int N_LINES  = 5;

    logic              pclk = 1'b0;
    logic              rst;
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic              enable;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] addr;
    logic [11:0]       dout;
    logic              we;
    logic              frame_done;
    logic              line_err;
    logic [7:0]        frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;
    int lo_cyc = 0;
    int n_fd = 0;
    int n_le = 0;
    logic [ADDR_W-1:0] wa[$];
    logic [11:0]       wd[$];
    int                wc[$];

    ov7670_capture_win #(
        .H_ACTIVE (H_ACTIVE),
        .CROP_X0  (2),
        .CROP_Y0  (1),
        .CROP_W   (2),
        .CROP_H   (2),
        .DECIM    (2),
        .ADDR_W   (ADDR_W)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .enable     (enable),
        .mode       (mode),
        .addr       (addr),
        .dout       (dout),
        .we         (we),
        .frame_done (frame_done),
        .line_err   (line_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc_cnt <= cyc_cnt + 1;

    // Log writes and status pulses, sampled on the falling edge
    always @(negedge pclk) begin
        if (!rst) begin
            if (we) begin
                wa.push_back(addr);
                wd.push_back(dout);
                wc.push_back(cyc_cnt);
            end
            if (frame_done) n_fd = n_fd + 1;
            if (line_err)   n_le = n_le + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        wa.delete();
        wd.delete();
        wc.delete();
        n_fd = 0;
        n_le = 0;
    endtask

    task automatic drive(input logic vs, input logic hr, input logic [7:0] dd);
        @(negedge pclk);
        vsync = vs;
        href  = hr;
        d     = dd;
    endtask

    // Sensor word at (x,y): pattern 0 marks the four kept pixels, pattern 1 is flat YUYV
    function automatic logic [15:0] pw(input int pat, input int x, input int y);
        if (pat == 1) return 16'hA53C;
        if (x == 2 && y == 1) return 16'hF81F;
        if (x == 4 && y == 1) return 16'h07E0;
        if (x == 2 && y == 3) return 16'h001F;
        if (x == 4 && y == 3) return 16'hFFFF;
        return 16'h5555;
    endfunction

    task automatic run_frame(input bit lead, input logic en, input logic [1:0] md,
                             input logic en_mid, input logic [1:0] md_mid,
                             input int pat, input int short_y);
        logic [15:0] w;
        int          nb;
        enable = en;
        mode   = md;
        if (lead) repeat (2) drive(1'b1, 1'b0, 8'h00);
        for (int y = 0; y < N_LINES; y++) begin
            repeat (2) drive(1'b0, 1'b0, 8'h00);
            if (y == 1) begin
                enable = en_mid;
                mode   = md_mid;
            end
            nb = (y == short_y) ? 15 : 16;
            for (int b = 0; b < nb; b++) begin
                w = pw(pat, b / 2, y);
                drive(1'b0, 1'b1, b[0] ? w[7:0] : w[15:8]);
                if (y == 1 && b == 5) lo_cyc = cyc_cnt;
            end
        end
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        repeat (3) drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [ADDR_W-1:0] ea,
                          input logic [11:0] ed);
        if (wa.size() > i) begin
            chk({tag, "_addr"}, 32'(wa[i]), 32'(ea));
            chk({tag, "_dout"}, 32'(wd[i]), 32'(ed));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; vsync = 1'b0; href = 1'b0; d = 8'h00; enable = 1'b0; mode = 2'b00;
        repeat (3) @(negedge pclk);
        chk("reset_outputs", 32'({addr, dout, we, frame_done, line_err, frame_cnt}), 32'd0);
        rst = 1'b0;

        // Lines arrive before any vsync pulse: must be ignored
        clr_log();
        run_frame(1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 0, -1);
        chk("unsynced_writes", 32'(wa.size()), 32'd0);
        chk("unsynced_fdone", 32'(n_fd), 32'd0);
        chk("unsynced_fcnt", 32'(frame_cnt), 32'd0);

        // RGB frame: four kept pixels in raster order
        clr_log();
        run_frame(1'b1, 1'b1, 2'b00, 1'b1, 2'b00, 0, -1);
        chk("rgb_writes", 32'(wa.size()), 32'd4);
        chk_wr("rgb_p0", 0, 3'd0, 12'hF0F);
        chk_wr("rgb_p1", 1, 3'd1, 12'h0F0);
        chk_wr("rgb_p2", 2, 3'd2, 12'h00F);
        chk_wr("rgb_p3", 3, 3'd3, 12'hFFF);
        if (wc.size() > 0) chk("rgb_latency", 32'(wc[0] - lo_cyc), 32'd1);
        chk("rgb_fdone", 32'(n_fd), 32'd1);
        chk("rgb_fcnt", 32'(frame_cnt), 32'd1);
        chk("rgb_lerr", 32'(n_le), 32'd0);

        // Grey frame from the Y byte
        clr_log();
        run_frame(1'b1, 1'b1, 2'b01, 1'b1, 2'b01, 1, -1);
        chk("grey_writes", 32'(wa.size()), 32'd4);
        chk_wr("grey_p0", 0, 3'd0, 12'hAAA);
        chk_wr("grey_p3", 3, 3'd3, 12'hAAA);
        chk("grey_fcnt", 32'(frame_cnt), 32'd2);

        // Capture not requested at frame start, raised mid-frame: nothing happens
        clr_log();
        run_frame(1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 0, -1);
        chk("off_writes", 32'(wa.size()), 32'd0);
        chk("off_fdone", 32'(n_fd), 32'd0);
        chk("off_fcnt", 32'(frame_cnt), 32'd2);

        // Mode 10 acts as RGB; enable/mode changes mid-frame ignored; short line y=2
        clr_log();
        run_frame(1'b1, 1'b1, 2'b10, 1'b0, 2'b01, 0, 2);
        chk("short_lerr", 32'(n_le), 32'd1);
        chk("short_writes", 32'(wa.size()), 32'd4);
        chk_wr("short_p2", 2, 3'd2, 12'h00F);
        chk_wr("short_p3", 3, 3'd3, 12'hFFF);
        chk("short_fcnt", 32'(frame_cnt), 32'd3);

        // Reset asserted right as the first kept pixel is being written
        clr_log();
        enable = 1'b1; mode = 2'b00;
        repeat (2) drive(1'b1, 1'b0, 8'h00);
        for (int y = 0; y < 2; y++) begin
            repeat (2) drive(1'b0, 1'b0, 8'h00);
            for (int b = 0; b < ((y == 1) ? 6 : 16); b++)
                drive(1'b0, 1'b1, b[0] ? pw(0, b / 2, y) & 16'h00FF : pw(0, b / 2, y) >> 8);
        end
        @(posedge pclk); #1;
        chk("pre_rst_we", 32'(we), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", 32'({addr, dout, we, frame_done, line_err, frame_cnt}), 32'd0);
        href = 1'b0;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        clr_log();
        run_frame(1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 0, -1);
        chk("post_rst_writes", 32'(wa.size()), 32'd0);
        chk("post_rst_fcnt", 32'(frame_cnt), 32'd0);
        clr_log();
        run_frame(1'b1, 1'b1, 2'b00, 1'b1, 2'b00, 0, -1);
        chk("resync_writes", 32'(wa.size()), 32'd4);
        chk_wr("resync_p0", 0, 3'd0, 12'hF0F);
        chk("resync_fcnt", 32'(frame_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
